// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: program-counter width and return-stack default depth.
package cpu_pkg;

   localparam int unsigned PC_W                 = 12;
   localparam int unsigned RSTACK_DEPTH_DEFAULT = 8;

endpackage : cpu_pkg

// File: rtl/rstack_mem.sv
// Return-stack entry storage: DEPTH x WIDTH registers, one write port, one asynchronous read port.
// Contents are deliberately not reset.
module rstack_mem
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = RSTACK_DEPTH_DEFAULT,
   parameter int unsigned WIDTH = PC_W,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule : rstack_mem

// File: rtl/return_stack.sv
// Hardware return-address LIFO for the program counter with full/empty tracking.
// Define RSTACK_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module return_stack
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = RSTACK_DEPTH_DEFAULT,
   parameter int unsigned WIDTH = PC_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             stack_in,
   output logic [WIDTH-1:0]             stack_out,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [CW-1:0]    sp_q, sp_d;
   logic             empty_c, full_c;
   logic             wr_en_c;
   logic [AW-1:0]    wr_addr_c;
   logic [AW-1:0]    rd_addr_c;
   logic [WIDTH-1:0] rd_data_c;

   assign empty_c   = (sp_q == '0);
   assign full_c    = (sp_q == CW'(DEPTH));
   assign rd_addr_c = AW'(sp_q - CW'(1));

   // Push/pop decode: simultaneous push+pop replaces the top, or pushes when empty.
   always_comb begin
      sp_d      = sp_q;
      wr_en_c   = 1'b0;
      wr_addr_c = '0;
      unique case ({push, pop})
         2'b10: begin
            if (!full_c) begin
               wr_en_c   = 1'b1;
               wr_addr_c = AW'(sp_q);
               sp_d      = sp_q + CW'(1);
            end
         end
         2'b01: begin
            if (!empty_c) begin
               sp_d = sp_q - CW'(1);
            end
         end
         2'b11: begin
            wr_en_c = 1'b1;
            if (empty_c) begin
               wr_addr_c = '0;
               sp_d      = CW'(1);
            end else begin
               wr_addr_c = rd_addr_c;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   rstack_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (wr_en_c & ~reset),
      .wr_addr_i (wr_addr_c),
      .wr_data_i (stack_in),
      .rd_addr_i (rd_addr_c),
      .rd_data_o (rd_data_c)
   );

   assign stack_out = empty_c ? '0 : rd_data_c;
   assign count     = sp_q;
   assign empty     = empty_c;
   assign full      = full_c;

`ifdef RSTACK_ERR_EN
   logic overflow_q, underflow_q;

   // Sticky error flags; a push+pop while full is a replace, not an overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_q  | (push & ~pop & full_c);
         underflow_q <= underflow_q | (pop & empty_c);
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule : return_stack

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: reference LIFO model plus a queue of expected pop-cycle outputs.
module tb_return_stack;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned WIDTH = 12;

   logic             clk = 1'b0;
   logic             reset, push, pop;
   logic [WIDTH-1:0] stack_in;
   logic [WIDTH-1:0] stack_out;
   logic [3:0]       count;
   logic             empty, full, overflow, underflow;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] mdl [$];
   logic [WIDTH-1:0] exp_q [$];
   bit               m_ovf, m_unf;

   always #5 clk = ~clk;

   return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .stack_in  (stack_in),
      .stack_out (stack_out),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus; pop cycles check stack_out before the edge retires the pop.
   task automatic op(input bit p, input bit q, input logic [WIDTH-1:0] d);
      push = p; pop = q; stack_in = d;
      if (q) exp_q.push_back(mdl.size() > 0 ? mdl[mdl.size()-1] : '0);
      @(negedge clk);
      if (q) chk("pop_out", int'(stack_out), int'(exp_q.pop_front()));
      @(posedge clk);
      #1;
      if (p && q) begin
         if (mdl.size() == 0) begin
            mdl.push_back(d);
            m_unf = 1'b1;
         end else begin
            mdl[mdl.size()-1] = d;
         end
      end else if (p) begin
         if (mdl.size() < DEPTH) mdl.push_back(d);
         else m_ovf = 1'b1;
      end else if (q) begin
         if (mdl.size() > 0) void'(mdl.pop_back());
         else m_unf = 1'b1;
      end
      push = 1'b0; pop = 1'b0; stack_in = '0;
   endtask

   task automatic check_state(input string tag);
      int exp_top;
      bit e_ovf, e_unf;
      exp_top = (mdl.size() > 0) ? int'(mdl[mdl.size()-1]) : 0;
`ifdef RSTACK_ERR_EN
      e_ovf = m_ovf;
      e_unf = m_unf;
`else
      e_ovf = 1'b0;
      e_unf = 1'b0;
`endif
      @(negedge clk);
      chk({tag, ".count"},     int'(count),     mdl.size());
      chk({tag, ".empty"},     int'(empty),     int'(mdl.size() == 0));
      chk({tag, ".full"},      int'(full),      int'(mdl.size() == DEPTH));
      chk({tag, ".top"},       int'(stack_out), exp_top);
      chk({tag, ".overflow"},  int'(overflow),  int'(e_ovf));
      chk({tag, ".underflow"}, int'(underflow), int'(e_unf));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit p, input logic [WIDTH-1:0] d);
      reset = 1'b1; push = p; stack_in = d;
      @(posedge clk);
      #1;
      reset = 1'b0; push = 1'b0; stack_in = '0;
      mdl.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   initial begin
      reset = 1'b0; push = 1'b0; pop = 1'b0; stack_in = '0;
      m_ovf = 1'b0; m_unf = 1'b0;
      do_reset(1'b0, '0);
      check_state("reset");

      // Basic LIFO order
      op(1, 0, 12'h010); op(1, 0, 12'h020); op(1, 0, 12'h030);
      check_state("push3");
      op(0, 1, '0); op(0, 1, '0); op(0, 1, '0);
      check_state("pop3");

      // Fill past depth, then drain
      for (int i = 0; i <= DEPTH; i++) op(1, 0, WIDTH'(12'h100 + i));
      check_state("overfill");
      for (int i = 0; i < DEPTH; i++) op(0, 1, '0);
      check_state("drain");

      // Replace top while full must not raise overflow
      do_reset(1'b0, '0);
      for (int i = 0; i < DEPTH; i++) op(1, 0, WIDTH'(12'h200 + i));
      op(1, 1, 12'h2AA);
      check_state("full_replace");

      // Empty pop, then push+pop on empty
      do_reset(1'b0, '0);
      op(0, 1, '0);
      check_state("empty_pop");
      op(1, 1, 12'h0AB);
      check_state("pushpop_empty");

      // Replace top with two entries
      do_reset(1'b0, '0);
      op(1, 0, 12'h011); op(1, 0, 12'h022);
      op(1, 1, 12'h033);
      check_state("replace");
      op(0, 1, '0); op(0, 1, '0);
      check_state("replace_drain");

      // Reset beats a simultaneous push and clears flags
      op(0, 1, '0);
      op(1, 0, 12'h001); op(1, 0, 12'h002); op(1, 0, 12'h003);
      do_reset(1'b1, 12'h055);
      check_state("reset_push");
      op(1, 0, 12'h066);
      check_state("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_return_stack
